// File: rtl/gpio_logic_unit.sv
// Clocked GPIO logic unit: synchronised header lanes and switches feed a
// mode-selected logic/arithmetic/counter/accumulator stage with registered outputs.
module gpio_logic_unit #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [2:0]   mode,
  input  logic         hold,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] y_out,
  output logic [W-1:0] pass_out,
  output logic         flag_out
);

  localparam int SW = 2*W + 4;

  logic [SYNC_STAGES-1:0][SW-1:0] sync_r;
  logic [SW-1:0]                  sync_in_s;
  logic [SW-1:0]                  sync_out_s;
  logic [W-1:0]                   a_s;
  logic [W-1:0]                   b_s;
  logic [2:0]                     mode_s;
  logic                           hold_s;
  logic [W-1:0]                   a_d_r;
  logic [W-1:0]                   b_d_r;
  logic [2:0]                     mode_p_r;
  logic [W-1:0]                   y_r;
  logic [W-1:0]                   pass_r;
  logic                           flag_r;
  logic                           rise_a_s;
  logic                           rise_b_s;
  logic                           entry_s;
  logic [W:0]                     add_s;
  logic [W:0]                     sub_s;
  logic [W:0]                     acc_s;
  logic [W-1:0]                   y_next_s;
  logic [W-1:0]                   pass_next_s;
  logic                           flag_next_s;

  assign sync_in_s  = {hold, mode, b_in, a_in};
  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign a_s        = sync_out_s[W-1:0];
  assign b_s        = sync_out_s[2*W-1:W];
  assign mode_s     = sync_out_s[2*W+2:2*W];
  assign hold_s     = sync_out_s[2*W+3];

  // Shift all asynchronous inputs through a common synchroniser chain.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sync_in_s};
    end
  end

  // Delayed copies for edge detection keep running even while held.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_d_r <= '0;
      b_d_r <= '0;
    end else begin
      a_d_r <= a_s;
      b_d_r <= b_s;
    end
  end

  assign rise_a_s = a_s[0] & ~a_d_r[0];
  assign rise_b_s = b_s[0] & ~b_d_r[0];
  assign entry_s  = (mode_s != mode_p_r) & (mode_s[2:1] == 2'b11);

  // A sum/difference one bit wider than the lane exposes carry and borrow in the MSB.
  assign add_s = {1'b0, a_s} + {1'b0, b_s};
  assign sub_s = {1'b0, a_s} - {1'b0, b_s};
  assign acc_s = {1'b0, y_r} + {1'b0, a_s};

  // Select the values loaded into the output registers this cycle.
  always_comb begin
    y_next_s    = y_r;
    pass_next_s = pass_r;
    flag_next_s = flag_r;
    if (hold_s) begin
      y_next_s    = y_r;
      pass_next_s = pass_r;
      flag_next_s = flag_r;
    end else begin
      case (mode_s)
        3'd0: begin
          y_next_s    = a_s;
          pass_next_s = b_s;
          flag_next_s = 1'b0;
        end
        3'd1: begin
          y_next_s    = a_s | b_s;
          pass_next_s = '0;
          flag_next_s = 1'b0;
        end
        3'd2: begin
          y_next_s    = a_s & b_s;
          pass_next_s = '0;
          flag_next_s = 1'b0;
        end
        3'd3: begin
          y_next_s    = a_s ^ b_s;
          pass_next_s = '0;
          flag_next_s = 1'b0;
        end
        3'd4: begin
          y_next_s    = add_s[W-1:0];
          pass_next_s = '0;
          flag_next_s = add_s[W];
        end
        3'd5: begin
          y_next_s    = sub_s[W-1:0];
          pass_next_s = '0;
          flag_next_s = sub_s[W];
        end
        3'd6: begin
          pass_next_s = '0;
          if (entry_s) begin
            y_next_s    = '0;
            flag_next_s = 1'b0;
          end else if (rise_a_s) begin
            y_next_s    = y_r + W'(1);
            flag_next_s = &y_r;
          end else begin
            y_next_s    = y_r;
            flag_next_s = 1'b0;
          end
        end
        3'd7: begin
          pass_next_s = '0;
          if (entry_s) begin
            y_next_s    = '0;
            flag_next_s = 1'b0;
          end else if (rise_b_s) begin
            y_next_s    = acc_s[W-1:0];
            flag_next_s = acc_s[W];
          end else begin
            y_next_s    = y_r;
            flag_next_s = flag_r;
          end
        end
        default: begin
          y_next_s    = '0;
          pass_next_s = '0;
          flag_next_s = 1'b0;
        end
      endcase
    end
  end

  // Output registers and previous-mode tracking, both frozen by hold.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      y_r      <= '0;
      pass_r   <= '0;
      flag_r   <= 1'b0;
      mode_p_r <= 3'd0;
    end else begin
      y_r    <= y_next_s;
      pass_r <= pass_next_s;
      flag_r <= flag_next_s;
      if (!hold_s) begin
        mode_p_r <= mode_s;
      end else begin
        mode_p_r <= mode_p_r;
      end
    end
  end

  assign y_out    = y_r;
  assign pass_out = pass_r;
  assign flag_out = flag_r;

endmodule

// File: tb/tb_gpio_logic_unit.sv
// Self-checking bench for gpio_logic_unit: table of mode vectors through a
// scoreboard queue, plus hand sequences for counter, accumulator, hold and entry.
module tb_gpio_logic_unit;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [2:0] mode;
  logic       hold;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [7:0] y_out;
  logic [7:0] pass_out;
  logic       flag_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [7:0] pass;
    logic       flag;
  } vec_t;

  vec_t vecs[9];
  vec_t exp_q[$];
  vec_t e;

  gpio_logic_unit #(.W(8), .SYNC_STAGES(2)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .mode    (mode),
    .hold    (hold),
    .a_in    (a_in),
    .b_in    (b_in),
    .y_out   (y_out),
    .pass_out(pass_out),
    .flag_out(flag_out)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic pulse_a();
    a_in[0] = 1'b1;
    tick(2);
    a_in[0] = 1'b0;
    tick(2);
  endtask

  task automatic pulse_b();
    b_in[0] = 1'b1;
    tick(2);
    b_in[0] = 1'b0;
    tick(2);
  endtask

  initial begin
    int hits;
    logic [8:0] acc_exp[3];

    Resetn = 1'b0;
    mode   = 3'd0;
    hold   = 1'b0;
    a_in   = 8'h00;
    b_in   = 8'h00;

    vecs[0] = '{3'd0, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 1'b0};
    vecs[1] = '{3'd1, 8'hF0, 8'h20, 8'hF0, 8'h00, 1'b0};
    vecs[2] = '{3'd2, 8'hF0, 8'h20, 8'h20, 8'h00, 1'b0};
    vecs[3] = '{3'd3, 8'hF0, 8'h20, 8'hD0, 8'h00, 1'b0};
    vecs[4] = '{3'd4, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1};
    vecs[5] = '{3'd4, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0};
    vecs[6] = '{3'd5, 8'h07, 8'h07, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{3'd0, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[8] = '{3'd5, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b1};

    acc_exp[0] = 9'h090;
    acc_exp[1] = 9'h120;
    acc_exp[2] = 9'h0B0;

    #12;
    check("reset y", y_out, 8'h00);
    check("reset pass", pass_out, 8'h00);
    check("reset flag", {7'd0, flag_out}, 8'h00);
    tick(1);
    Resetn = 1'b1;
    tick(3);

    // PASS with exact three-edge latency
    mode = 3'd0;
    a_in = 8'h3C;
    b_in = 8'hA5;
    tick(2);
    check("pass latency early y", y_out, 8'h00);
    tick(1);
    check("pass y", y_out, 8'h3C);
    check("pass pass", pass_out, 8'hA5);

    // asynchronous reset mid-run
    #2 Resetn = 1'b0;
    #1;
    check("midrun reset y", y_out, 8'h00);
    check("midrun reset pass", pass_out, 8'h00);
    tick(1);
    Resetn = 1'b1;
    tick(1);

    for (int i = 0; i < 9; i++) begin
      mode = vecs[i].mode;
      a_in = vecs[i].a;
      b_in = vecs[i].b;
      exp_q.push_back(vecs[i]);
      tick(3);
      e = exp_q.pop_front();
      check($sformatf("vec%0d y", i), y_out, e.y);
      check($sformatf("vec%0d pass", i), pass_out, e.pass);
      check($sformatf("vec%0d flag", i), {7'd0, flag_out}, {7'd0, e.flag});
    end

    // COUNT wrap
    mode = 3'd6;
    a_in = 8'h00;
    b_in = 8'h00;
    tick(4);
    check("count entry y", y_out, 8'h00);
    for (int i = 0; i < 255; i++) pulse_a();
    tick(2);
    check("count 255 y", y_out, 8'hFF);
    check("count 255 flag", {7'd0, flag_out}, 8'h00);
    hits = 0;
    a_in[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (i == 1) a_in[0] = 1'b0;
      if (flag_out) hits++;
    end
    check("count wrap y", y_out, 8'h00);
    check("count wrap flag cycles", 8'(hits), 8'd1);

    // ACC
    mode = 3'd7;
    a_in = 8'h90;
    tick(4);
    check("acc entry y", y_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{3'd7, 8'h90, 8'h00, acc_exp[i][7:0], 8'h00, acc_exp[i][8]});
      pulse_b();
      tick(2);
      e = exp_q.pop_front();
      check($sformatf("acc%0d y", i), y_out, e.y);
      check($sformatf("acc%0d flag", i), {7'd0, flag_out}, {7'd0, e.flag});
    end

    // Hold in COUNT
    mode = 3'd6;
    a_in = 8'h00;
    b_in = 8'h00;
    tick(4);
    for (int i = 0; i < 5; i++) pulse_a();
    check("hold pre y", y_out, 8'h05);
    hold = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) pulse_a();
    mode = 3'd4;
    b_in = 8'h33;
    tick(4);
    mode = 3'd6;
    b_in = 8'h00;
    tick(4);
    check("held y", y_out, 8'h05);
    hold = 1'b0;
    tick(4);
    check("released y", y_out, 8'h05);
    pulse_a();
    check("released pulse y", y_out, 8'h06);

    // Mode change during hold fires entry on release
    hold = 1'b1;
    tick(4);
    mode = 3'd7;
    tick(4);
    check("held mode change y", y_out, 8'h06);
    hold = 1'b0;
    tick(4);
    check("late entry y", y_out, 8'h00);

    // Entry beats a simultaneous rise
    mode = 3'd0;
    a_in = 8'h00;
    tick(4);
    mode = 3'd6;
    a_in = 8'h01;
    tick(5);
    check("entry collision y", y_out, 8'h00);
    a_in = 8'h00;
    tick(2);
    pulse_a();
    check("post collision y", y_out, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
